// File: rtl/audio_sd_dac_if.sv
// Sample stream handshake from the voice mixer into the sigma-delta output stage.
// The mixer drives data/valid; the DAC returns ready when its one-entry buffer is empty.
interface audio_sd_dac_if #(
  parameter int unsigned WIDTH = 18
);
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  modport master (
    output s_data,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    output s_ready
  );
endinterface

// File: rtl/audio_sd_dac.sv
// First-order sigma-delta audio DAC with one-sample buffer and sample-rate tick.
// Optional LFSR dither is enabled by defining SD_DAC_DITHER_EN.
module audio_sd_dac #(
  parameter int unsigned WIDTH   = 18,
  parameter int unsigned CLK_DIV = 1134
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  audio_sd_dac_if.slave       s_if,
  output logic                sample_tick,
  output logic                underrun,
  output logic [7:0]          underrun_cnt,
  output logic                dac_out
);

  localparam int unsigned     CntW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CntW-1:0] DivLast = CntW'(CLK_DIV - 1);
  localparam logic [WIDTH-1:0] Mid   = {1'b1, {(WIDTH-1){1'b0}}};

  logic [CntW-1:0]  r_div_cnt;
  logic             r_buf_full;
  logic [WIDTH-1:0] r_buf;
  logic [WIDTH-1:0] r_active;
  logic [WIDTH-1:0] r_acc;
  logic             r_dac;
  logic             r_sample_tick;
  logic             r_underrun;
  logic [7:0]       r_underrun_cnt;

  logic             w_tick;
  logic             w_xfer;
  logic [WIDTH:0]   w_sum;

  assign w_tick      = (r_div_cnt == DivLast);
  assign s_if.s_ready = rst_n & ~r_buf_full;
  assign w_xfer      = s_if.s_valid & s_if.s_ready;

  // Divider, buffer and active-sample update. At the tick a full buffer always wins;
  // an empty buffer with valid input bypasses straight into the active sample.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div_cnt      <= '0;
      r_buf_full     <= 1'b0;
      r_buf          <= Mid;
      r_active       <= Mid;
      r_sample_tick  <= 1'b0;
      r_underrun     <= 1'b0;
      r_underrun_cnt <= '0;
    end else begin
      r_div_cnt     <= w_tick ? '0 : r_div_cnt + 1'b1;
      r_sample_tick <= w_tick;
      r_underrun    <= 1'b0;
      if (w_tick) begin
        if (r_buf_full) begin
          r_active   <= enable ? r_buf : Mid;
          r_buf_full <= 1'b0;
        end else if (s_if.s_valid) begin
          r_active <= enable ? s_if.s_data : Mid;
        end else begin
          r_underrun <= 1'b1;
          if (!enable) begin
            r_active <= Mid;
          end
          if (r_underrun_cnt != 8'hFF) begin
            r_underrun_cnt <= r_underrun_cnt + 8'd1;
          end
        end
      end else if (w_xfer) begin
        r_buf      <= s_if.s_data;
        r_buf_full <= 1'b1;
      end
    end
  end

`ifdef SD_DAC_DITHER_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end

  // Carry out of the WIDTH+1 bit sum is dropped, so dither wraps rather than clamps.
  always_comb begin
    w_sum = {1'b0, r_acc} + {1'b0, r_active} + (WIDTH+1)'(r_lfsr[1:0]);
  end
`else
  always_comb begin
    w_sum = {1'b0, r_acc} + {1'b0, r_active};
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_dac <= 1'b0;
    end else begin
      r_acc <= w_sum[WIDTH-1:0];
      r_dac <= w_sum[WIDTH];
    end
  end

  assign sample_tick  = r_sample_tick;
  assign underrun     = r_underrun;
  assign underrun_cnt = r_underrun_cnt;
  assign dac_out      = r_dac;

endmodule

// File: tb/tb_audio_sd_dac.sv
// Directed bench for audio_sd_dac: a cycle model of divider, buffer and underrun counter
// feeds a sample queue that is checked at every tick; dac_out density is checked by counting.
module tb_audio_sd_dac;

  localparam int unsigned W   = 18;
  localparam int unsigned DIV = 8;
  localparam logic [W-1:0] MID = 18'h20000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic       sample_tick;
  logic       underrun;
  logic [7:0] underrun_cnt;
  logic       dac_out;

  audio_sd_dac_if #(.WIDTH(W)) s_if ();

  audio_sd_dac #(
    .WIDTH  (W),
    .CLK_DIV(DIV)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .s_if        (s_if.slave),
    .sample_tick (sample_tick),
    .underrun    (underrun),
    .underrun_cnt(underrun_cnt),
    .dac_out     (dac_out)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail = 0;
  logic [W-1:0] q[$];
  int         m_div = 0;
  logic       m_tick = 1'b0;
  logic       m_under = 1'b0;
  logic [W-1:0] m_active = MID;
  int         m_ucnt = 0;
  int         ones = 0;
  int         same = 0;
  logic       prev_dac = 1'b0;
  bit         last_xfer = 1'b0;
  int         base;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample inputs before the edge, advance the model, compare after the edge.
  task automatic step();
    bit rs;
    bit en;
    bit xf;
    logic [W-1:0] d;
    #1;
    rs = rst_n;
    en = enable;
    d  = s_if.s_data;
    xf = (rst_n && s_if.s_valid && s_if.s_ready) === 1'b1;
    @(posedge clk);
    #1;
    last_xfer = xf;
    m_under   = 1'b0;
    if (!rs) begin
      m_div    = 0;
      m_tick   = 1'b0;
      m_active = MID;
      m_ucnt   = 0;
      q.delete();
    end else begin
      m_tick = (m_div == DIV - 1);
      m_div  = m_tick ? 0 : m_div + 1;
      if (xf) q.push_back(d);
      if (m_tick) begin
        if (q.size() > 0) begin
          m_active = q.pop_front();
          if (!en) m_active = MID;
        end else begin
          m_under = 1'b1;
          if (!en) m_active = MID;
          if (m_ucnt < 255) m_ucnt++;
        end
      end
    end
    if (dac_out === prev_dac) same++;
    prev_dac = dac_out;
    if (dac_out === 1'b1) ones++;
    check("sample_tick", {31'd0, sample_tick}, {31'd0, m_tick});
    check("underrun", {31'd0, underrun}, {31'd0, m_under});
    if (m_tick) begin
      check("active", 32'(dut.r_active), 32'(m_active));
      check("underrun_cnt", 32'(underrun_cnt), 32'(m_ucnt));
    end
  endtask

  task automatic send(input logic [W-1:0] d);
    bit done;
    done = 1'b0;
    s_if.s_valid = 1'b1;
    s_if.s_data  = d;
    for (int i = 0; i < 4 * DIV && !done; i++) begin
      step();
      done = last_xfer;
    end
    s_if.s_valid = 1'b0;
    check("send_accepted", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_ticks(input int n);
    int seen;
    seen = 0;
    for (int i = 0; i < n * DIV + 2 * DIV && seen < n; i++) begin
      step();
      if (m_tick) seen++;
    end
    check("tick_budget", 32'(seen), 32'(n));
  endtask

  task automatic wait_div(input int target);
    for (int i = 0; i < 2 * DIV && m_div != target; i++) step();
    check("div_align", 32'(m_div), 32'(target));
  endtask

  initial begin
    s_if.s_valid = 1'b1;
    s_if.s_data  = 18'h3FFFF;

    // Reset with valid held high
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_s_ready", {31'd0, s_if.s_ready}, 32'd0);
      check("reset_dac_out", {31'd0, dac_out}, 32'd0);
    end
    check("reset_ucnt", 32'(underrun_cnt), 32'd0);
    rst_n        = 1'b1;
    s_if.s_valid = 1'b0;
    step();
    check("release_s_ready", {31'd0, s_if.s_ready}, 32'd1);

`ifndef SD_DAC_DITHER_EN
    // Midscale: strict alternation
    for (int k = 0; k < 6; k++) send(MID);
    ones = 0;
    same = 0;
    for (int i = 0; i < 64; i++) step();
    check("mid_ones64", 32'(ones), 32'd32);
    check("mid_toggle", 32'(same), 32'd0);

    send(18'h30000);
    wait_ticks(1);
    step();
    step();
    ones = 0;
    for (int i = 0; i < 64; i++) step();
    check("dens_3q_ones64", 32'(ones), 32'd48);

    send(18'h00000);
    wait_ticks(1);
    step();
    step();
    ones = 0;
    for (int i = 0; i < 64; i++) step();
    check("dens_zero_ones64", 32'(ones), 32'd0);
`else
    ones = 0;
    for (int i = 0; i < 65536; i++) step();
    check("dither_density", {31'd0, (ones >= 32704 && ones <= 32832)}, 32'd1);
`endif

    // Handshake: second sample waits for the tick to drain the buffer
    wait_div(2);
    s_if.s_valid = 1'b1;
    s_if.s_data  = 18'h11111;
    step();
    check("hs_first_accept", {31'd0, last_xfer}, 32'd1);
    s_if.s_data = 18'h22222;
    check("hs_full_ready", {31'd0, s_if.s_ready}, 32'd0);
    for (int i = 0; i < 2 * DIV; i++) begin
      step();
      if (m_tick) break;
      check("hs_hold_ready", {31'd0, s_if.s_ready}, 32'd0);
    end
    check("hs_active", 32'(dut.r_active), 32'h11111);
    check("hs_drained_ready", {31'd0, s_if.s_ready}, 32'd1);
    step();
    check("hs_second_accept", {31'd0, last_xfer}, 32'd1);
    s_if.s_valid = 1'b0;
    check("hs_second_full", {31'd0, s_if.s_ready}, 32'd0);

    // Underrun: one tick drains 0x22222, then three empty ticks
    base = m_ucnt;
    wait_ticks(4);
    check("ur_cnt_plus3", 32'(underrun_cnt), 32'((base + 3 > 255) ? 255 : base + 3));
    check("ur_active_held", 32'(dut.r_active), 32'h22222);
    wait_ticks(300);
    check("ur_saturate", 32'(underrun_cnt), 32'd255);

    // Bypass: valid first raised in the tick cycle
    wait_div(DIV - 1);
    s_if.s_valid = 1'b1;
    s_if.s_data  = 18'h2AAAA;
    step();
    s_if.s_valid = 1'b0;
    check("bypass_xfer", {31'd0, last_xfer}, 32'd1);
    check("bypass_no_underrun", {31'd0, underrun}, 32'd0);
    check("bypass_active", 32'(dut.r_active), 32'h2AAAA);
    check("bypass_buf_empty", {31'd0, s_if.s_ready}, 32'd1);

    // Mute: buffered sample is drained but midscale is loaded
    send(18'h0F0F0);
    enable = 1'b0;
    wait_ticks(1);
    check("mute_active", 32'(dut.r_active), 32'(MID));
    check("mute_drained", {31'd0, s_if.s_ready}, 32'd1);
    enable = 1'b1;

    // Mid-period reset discards the buffered sample
    send(18'h12345);
    step();
    rst_n = 1'b0;
    step();
    step();
    check("midrst_s_ready", {31'd0, s_if.s_ready}, 32'd0);
    rst_n = 1'b1;
    step();
    check("midrst_release_ready", {31'd0, s_if.s_ready}, 32'd1);
    wait_ticks(1);
    check("midrst_active", 32'(dut.r_active), 32'(MID));
    check("midrst_ucnt", 32'(underrun_cnt), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
